// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_t   : LSU control states
//   F3_*          : RV32I funct3 encodings for load/store sizes
//   is_misaligned : true when an access cannot be issued to the word RAM
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Illegal size encodings are folded into the misaligned error so the
  // core only ever sees one kind of access fault.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] byte_off);
    logic bad;
    bad = 1'b1;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = byte_off[0];
      F3_W:        bad = (byte_off != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational load data alignment and extension.
//   word     in  32  raw word read from the data RAM
//   byte_off in  2   low address bits selecting the starting byte lane
//   funct3   in  3   load size/sign encoding
//   result   out 32  right-aligned, sign- or zero-extended load value
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {byte_off, 3'b000};
    result  = shifted;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'd0, shifted[7:0]};
      F3_HU:   result = {16'd0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage between the ALU and writeback.
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/ready/we/funct3/addr/wdata   core request (ready/valid)
//   mem_req/we/addr/wstrb/wdata, mem_gnt   word RAM request channel
//   mem_rvalid/rdata                       word RAM read response
//   rsp_valid/rdata/err                    one-cycle completion to writeback
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  lsu_state_t        state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ext_data;
  logic [3:0]        lane_strb;
  logic [DATA_W-1:0] lane_data;
  logic              capture;
  logic              in_req;

  // Extension works straight off the RAM bus so the result can be
  // registered in the same edge that the read data arrives.
  load_extend u_load_extend (
    .word     (mem_rdata),
    .byte_off (addr_q[1:0]),
    .funct3   (funct3_q),
    .result   (ext_data)
  );

  assign capture = !we_q && mem_rvalid &&
                   ((state_q == REQ && mem_gnt) || state_q == WAIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid)
              state_d = is_misaligned(req_funct3, req_addr[1:0]) ? ERR : REQ;
      REQ:  if (mem_gnt)
              state_d = (we_q || mem_rvalid) ? DONE : WAIT;
      WAIT: if (mem_rvalid) state_d = DONE;
      DONE: state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      // Stores and errors complete with zero data; loads with the
      // extended word. Only entry into DONE/ERR updates the result.
      if (state_d == DONE || state_d == ERR)
        rdata_q <= capture ? ext_data : '0;
    end
  end

  // Store data is replicated across all lanes so the strobes alone pick
  // the bytes that land in RAM.
  always_comb begin
    lane_strb = 4'b0000;
    lane_data = wdata_q;
    case (funct3_q)
      F3_B: begin
        lane_strb = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        lane_strb = 4'b0011 << addr_q[1:0];
        lane_data = {2{wdata_q[15:0]}};
      end
      F3_W: lane_strb = 4'b1111;
      default: lane_strb = 4'b0000;
    endcase
    if (!we_q) lane_strb = 4'b0000;
  end

  assign in_req    = (state_q == REQ);
  assign req_ready = (state_q == IDLE);
  assign mem_req   = in_req;
  assign mem_we    = in_req && we_q;
  assign mem_addr  = in_req ? {addr_q[DATA_W-1:2], 2'b00} : '0;
  assign mem_wstrb = in_req ? lane_strb : 4'b0000;
  assign mem_wdata = in_req ? lane_data : '0;
  assign rsp_valid = (state_q == DONE) || (state_q == ERR);
  assign rsp_err   = (state_q == ERR);
  assign rsp_rdata = rdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU. Takes the ALU result as the effective byte address, plus store data and funct3, and performs one RV32I load or store against a word-wide data RAM that may insert wait states. Holds the core with a ready/valid handshake until the access completes. Returns sign- or zero-extended load data, or a misalignment error, to the writeback path.

## Interface
- `DATA_W`, 32: data and address width (fixed at 32 for RV32I).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  core presents an access this cycle.
- `req_ready`  out  1  LSU can accept a request; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  access size and sign, per RV32I encoding.
- `req_addr`  in  32  effective byte address (ALU result).
- `req_wdata`  in  32  store data (rs2); the low bytes are used.
- `mem_req`  out  1  RAM request; held until granted.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  32  word-aligned address, `{req_addr[31:2], 2'b00}`.
- `mem_wstrb`  out  4  byte strobes.
- `mem_wdata`  out  32  store data shifted into the addressed lanes.
- `mem_gnt`  in  1  RAM accepted the request.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  raw read word.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and on error.
- `rsp_err`  out  1  misaligned access; qualified by `rsp_valid`.

## Operation

**States**

- **IDLE**
  - Accepts a request when `req_valid`.
  - Latches `we`, `funct3`, `addr` and `wdata`.
  - Computes misalignment:
    - halfword with `addr[0] == 1`;
    - word with `addr[1:0] != 0`;
    - `funct3` 011, 110 or 111 is illegal and is treated as misaligned.
  - Misaligned → ERR. Otherwise → REQ.
- **REQ**
  - `mem_req = 1`. `mem_addr`, `mem_we`, `mem_wstrb` and `mem_wdata` are stable while in this state.
  - `mem_gnt` with a store → DONE.
  - `mem_gnt` with a load and `mem_rvalid` in the same cycle → capture data, → DONE.
  - `mem_gnt` with a load, no `mem_rvalid` → WAIT.
- **WAIT**
  - `mem_req = 0`.
  - On `mem_rvalid`: capture `mem_rdata`, → DONE.
- **DONE**
  - `rsp_valid = 1`, `rsp_err = 0` for one cycle, then → IDLE.
- **ERR**
  - `rsp_valid = 1`, `rsp_err = 1`, `rsp_rdata = 0` for one cycle, then → IDLE.
  - No memory access is made.

**Store lanes** (`a = addr[1:0]`)

- SB (000): `wstrb = 4'b0001 << a`; `wdata = {4{wdata[7:0]}}`.
- SH (001): `wstrb = 4'b0011 << a`; `wdata = {2{wdata[15:0]}}`.
- SW (010): `wstrb = 4'b1111`; `wdata` unchanged.
- `mem_wstrb = 0` on loads.

**Load extract**

- Shift the captured word right by `8*a`.
- LB (000): sign-extend bit 7.
- LH (001): sign-extend bit 15.
- LW (010): unchanged.
- LBU (100): zero-extend 8 bits.
- LHU (101): zero-extend 16 bits.
- `rsp_rdata` is registered and holds its value until the next completion.

**Protocol rules**

- Unsolicited `mem_rvalid` in IDLE, DONE or ERR is ignored.
- `mem_rvalid` in REQ without `mem_gnt` is ignored.
- `req_valid` outside IDLE is ignored; the core must hold its request until `req_ready`.

## Timing
- **Reset**
  - `rst_n = 0` at an edge forces IDLE and clears all registers.
  - Reset values:
    - `req_ready = 1`;
    - `mem_req`, `mem_we`, `mem_wstrb`, `mem_addr`, `mem_wdata` = 0;
    - `rsp_valid`, `rsp_err`, `rsp_rdata` = 0.
  - Reset mid-access abandons the transaction with no response pulse. A late `mem_rvalid` after reset is ignored.
- **Latency** (acceptance edge to `rsp_valid`)
  - Store, zero wait: 2 cycles (IDLE → REQ → DONE).
  - Load with gnt and rvalid together: 2 cycles.
  - Each cycle of gnt delay or rvalid delay adds 1.
  - Misaligned: 1 cycle (IDLE → ERR).
- **Outputs:** all outputs are registered or decoded from state only; no combinational path from `mem_*` inputs to `mem_*` outputs.
- **Throughput:** back-to-back requests: the next acceptance occurs in the IDLE cycle that follows DONE or ERR.

## Structure
- Package `lsu_pkg`:
  - `typedef enum logic [2:0] lsu_state_t {IDLE, REQ, WAIT, DONE, ERR}`;
  - funct3 constants `F3_B=3'b000`, `F3_H=3'b001`, `F3_W=3'b010`, `F3_BU=3'b100`, `F3_HU=3'b101`.
- Sub-module `load_extend`:
  - combinational;
  - inputs: word, `addr[1:0]`, `funct3`;
  - output: 32-bit extended result.
- Store-lane generation stays inline.

## Test plan
1. SW, `addr=0x100`, `wdata=0xDEADBEEF`, gnt on the first REQ cycle → `mem_addr=0x100`, `wstrb=1111`; `rsp_valid` 2 cycles after acceptance; `rsp_err=0`.
2. SB, `addr=0x103`, `wdata=0x000000A5` → `wstrb=1000`, `mem_wdata=0xA5A5A5A5`, `mem_addr=0x100`.
3. LB and LBU at `addr=0x202`, `mem_rdata=0x12F45678`, rvalid 3 cycles after gnt → LB returns `0xFFFFFFF4`, LBU returns `0x000000F4`; latency 5 cycles.
4. LH at `0x301` and LW at `0x302` → `rsp_err=1`, `rsp_rdata=0`, `mem_req` never asserted; `rsp_valid` 1 cycle after acceptance.
5. `mem_gnt` held low for 4 cycles during LW → `mem_req` and `mem_addr` stable throughout; `req_ready=0` throughout; extra `req_valid` pulses are ignored.
6. `rst_n` low while in WAIT → next cycle IDLE with all outputs 0; a subsequent `mem_rvalid` produces no `rsp_valid`.
